// File: rtl/alu16_pkg.sv
// Shared definitions for the 16-bit ALU and its operand stage.
// Opcode map and datapath widths.
package alu16_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 16;

    localparam logic [3:0] OP_AND       = 4'd0;
    localparam logic [3:0] OP_OR        = 4'd1;
    localparam logic [3:0] OP_ADD       = 4'd2;
    localparam logic [3:0] OP_SUB       = 4'd3;
    localparam logic [3:0] OP_XOR       = 4'd4;
    localparam logic [3:0] OP_NOR       = 4'd5;
    localparam logic [3:0] OP_NAND      = 4'd6;
    localparam logic [3:0] OP_SLT       = 4'd7;
    localparam logic [3:0] OP_MAX_VALID = 4'd7;

endpackage

// File: rtl/reg_file16.sv
// General register file: two read ports, one write port.
// r0 reads as zero; a same-cycle write is bypassed to the reads.
module reg_file16
    import alu16_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0] raddr_a,
    input  logic [REG_ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0]     rdata_a,
    output logic [DATA_W-1:0]     rdata_b
);

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr;

    assign wr = we && (waddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (wr && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end else if (raddr_a != '0) begin
            rdata_a = regs[raddr_a];
        end
        if (wr && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end else if (raddr_b != '0) begin
            rdata_b = regs[raddr_b];
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand fetch ahead of the 16-bit ALU: register read, immediate,
// bypass, and a one-entry valid/ready output register.
module alu_operand_stage
    import alu16_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int IMM_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic [IMM_W-1:0]      imm,
    input  logic                  use_imm,
    input  logic [3:0]            op_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     A,
    output logic [DATA_W-1:0]     B,
    output logic [3:0]            op,
    output logic [REG_ADDR_W-1:0] dest_out,
    output logic                  illegal_op
);

    logic [DATA_W-1:0]     rd_a;
    logic [DATA_W-1:0]     rd_b;
    logic [DATA_W-1:0]     imm_sext;
    logic [DATA_W-1:0]     b_next;
    logic [3:0]            op_next;
    logic                  ill_next;
    logic                  accept;
    logic                  wb_live;
    logic                  hit_rs;
    logic                  hit_rt;
    logic [REG_ADDR_W-1:0] rs_q;
    logic [REG_ADDR_W-1:0] rt_q;
    logic                  use_imm_q;

    reg_file16 #(.NREGS(NREGS)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs_addr),
        .raddr_b (rt_addr),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign b_next   = use_imm ? imm_sext : rd_b;
    assign ill_next = op_in > OP_MAX_VALID;
    assign op_next  = ill_next ? OP_AND : op_in;

    // Write-back landing on a held source keeps stalled operands fresh.
    assign wb_live = wb_en && (wb_addr != '0);
    assign hit_rs  = wb_live && (wb_addr == rs_q);
    assign hit_rt  = wb_live && (wb_addr == rt_q) && !use_imm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            A          <= '0;
            B          <= '0;
            op         <= '0;
            dest_out   <= '0;
            illegal_op <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            use_imm_q  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            A          <= rd_a;
            B          <= b_next;
            op         <= op_next;
            dest_out   <= dest_in;
            illegal_op <= ill_next;
            rs_q       <= rs_addr;
            rt_q       <= rt_addr;
            use_imm_q  <= use_imm;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else if (out_valid) begin
            if (hit_rs) A <= wb_data;
            if (hit_rt) B <= wb_data;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vector table, reset sequence,
// and random traffic against a transaction-level reference model.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  rs_addr, rt_addr, op_in, dest_in, wb_addr;
    logic [7:0]  imm;
    logic        use_imm, wb_en, flush, out_valid, out_ready;
    logic [15:0] wb_data, A, B;
    logic [3:0]  op, dest_out;
    logic        illegal_op;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .imm(imm), .use_imm(use_imm),
        .op_in(op_in), .dest_in(dest_in), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .A(A), .B(B), .op(op), .dest_out(dest_out),
        .illegal_op(illegal_op)
    );

    typedef struct {
        logic        iv;
        logic [3:0]  rs, rt;
        logic        ui;
        logic [7:0]  im;
        logic [3:0]  opi, dst;
        logic        wbe;
        logic [3:0]  wba;
        logic [15:0] wbd;
        logic        fl, ordy;
        logic        e_rdy, e_v;
        logic [15:0] e_a, e_b;
        logic [3:0]  e_op, e_dst;
        logic        e_ill;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: architectural registers plus the one
    // instruction the stage is holding for the ALU.
    int unsigned regs[16];
    bit          m_v;
    int unsigned m_a, m_b, m_op, m_dst, m_ill;
    int unsigned m_rs, m_rt;
    bit          m_ui;
    bit          m_rdy;
    bit          m_rst;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(logic iv, logic [3:0] rs, logic [3:0] rt, logic ui,
                       logic [7:0] im, logic [3:0] opi, logic [3:0] dst,
                       logic wbe, logic [3:0] wba, logic [15:0] wbd,
                       logic fl, logic ordy, logic e_rdy, logic e_v,
                       logic [15:0] e_a, logic [15:0] e_b, logic [3:0] e_op,
                       logic [3:0] e_dst, logic e_ill);
        vec_t v;
        v.iv = iv; v.rs = rs; v.rt = rt; v.ui = ui; v.im = im;
        v.opi = opi; v.dst = dst; v.wbe = wbe; v.wba = wba; v.wbd = wbd;
        v.fl = fl; v.ordy = ordy; v.e_rdy = e_rdy; v.e_v = e_v;
        v.e_a = e_a; v.e_b = e_b; v.e_op = e_op; v.e_dst = e_dst;
        v.e_ill = e_ill;
        vecs.push_back(v);
    endtask

    task automatic idle();
        rst = 0; in_valid = 0; rs_addr = 0; rt_addr = 0; imm = 0;
        use_imm = 0; op_in = 0; dest_in = 0; wb_en = 0; wb_addr = 0;
        wb_data = 0; flush = 0; out_ready = 1;
    endtask

    function automatic int unsigned rd(int unsigned a);
        if (wb_en && wb_addr != 0 && wb_addr == a) return wb_data;
        if (a == 0) return 0;
        return regs[a];
    endfunction

    // One clock: evaluate the model on the current inputs, then advance.
    task automatic cycle();
        bit          acc;
        bit          n_v;
        int unsigned n_a, n_b, n_op, n_dst, n_ill, n_rs, n_rt;
        bit          n_ui;
        #1;
        m_rst = rst;
        m_rdy = !flush && (!m_v || out_ready);
        acc = in_valid && m_rdy;
        n_v = m_v; n_a = m_a; n_b = m_b; n_op = m_op; n_dst = m_dst;
        n_ill = m_ill; n_rs = m_rs; n_rt = m_rt; n_ui = m_ui;
        if (rst) begin
            n_v = 0; n_a = 0; n_b = 0; n_op = 0; n_dst = 0; n_ill = 0;
        end else if (flush) begin
            n_v = 0;
        end else if (acc) begin
            n_v = 1;
            n_a = rd(rs_addr);
            if (use_imm) n_b = (imm >= 128) ? imm + 16'hFF00 : imm;
            else         n_b = rd(rt_addr);
            n_ill = (op_in >= 8);
            n_op = n_ill ? 0 : op_in;
            n_dst = dest_in;
            n_rs = rs_addr; n_rt = rt_addr; n_ui = use_imm;
        end else if (m_v && out_ready) begin
            n_v = 0;
        end else if (m_v) begin
            if (wb_en && wb_addr != 0 && wb_addr == m_rs) n_a = wb_data;
            if (wb_en && wb_addr != 0 && wb_addr == m_rt && !m_ui)
                n_b = wb_data;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            foreach (regs[i]) regs[i] = 0;
        end else if (wb_en && wb_addr != 0) begin
            regs[wb_addr] = wb_data;
        end
        m_v = n_v; m_a = n_a; m_b = n_b; m_op = n_op; m_dst = n_dst;
        m_ill = n_ill; m_rs = n_rs; m_rt = n_rt; m_ui = n_ui;
    endtask

    initial begin
        idle();
        foreach (regs[i]) regs[i] = 0;
        m_v = 0; m_a = 0; m_b = 0; m_op = 0; m_dst = 0; m_ill = 0;
        m_rs = 0; m_rt = 0; m_ui = 0;

        // Reset state
        rst = 1;
        cycle();
        rst = 0;
        chk("reset out_valid", out_valid, 0);
        chk("reset A", A, 0);
        chk("reset B", B, 0);
        chk("reset op", op, 0);
        chk("reset dest", dest_out, 0);
        chk("reset illegal", illegal_op, 0);

        //  iv rs rt ui im    op dst wbe wba wbd      fl ordy rdy v  A        B        op dst ill
        add(0, 0, 0, 0, 8'h00, 0, 0, 1, 3, 16'h1234, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 8'h00, 0, 0, 1, 5, 16'h00FF, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 3, 5, 0, 8'h00, 2, 7, 0, 0, 16'h0000, 0, 1, 1, 1, 16'h1234, 16'h00FF, 2, 7, 0);
        add(1, 4, 0, 0, 8'h00, 1, 1, 1, 4, 16'hBEEF, 0, 1, 1, 1, 16'hBEEF, 16'h0000, 1, 1, 0);
        add(1, 0, 4, 0, 8'h00, 3, 2, 1, 0, 16'h5555, 0, 1, 1, 1, 16'h0000, 16'hBEEF, 3, 2, 0);
        add(1, 3, 0, 1, 8'h80, 4, 3, 0, 0, 16'h0000, 0, 1, 1, 1, 16'h1234, 16'hFF80, 4, 3, 0);
        add(1, 5, 0, 1, 8'h7F, 0, 4, 0, 0, 16'h0000, 0, 1, 1, 1, 16'h00FF, 16'h007F, 0, 4, 0);
        add(1, 3, 5, 0, 8'h00, 2, 5, 0, 0, 16'h0000, 0, 1, 1, 1, 16'h1234, 16'h00FF, 2, 5, 0);
        add(1, 1, 1, 0, 8'h00, 6, 9, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h1234, 16'h00FF, 2, 5, 0);
        add(0, 0, 0, 0, 8'h00, 0, 0, 1, 3, 16'h0042, 0, 0, 0, 1, 16'h0042, 16'h00FF, 2, 5, 0);
        add(0, 0, 0, 0, 8'h00, 0, 0, 1, 5, 16'h0077, 0, 0, 0, 1, 16'h0042, 16'h0077, 2, 5, 0);
        add(1, 5, 3, 0, 8'h00, 7, 6, 0, 0, 16'h0000, 0, 1, 1, 1, 16'h0077, 16'h0042, 7, 6, 0);
        add(1, 1, 2, 0, 8'h00, 9, 8, 0, 0, 16'h0000, 0, 1, 1, 1, 16'h0000, 16'h0000, 0, 8, 1);
        add(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 8, 1);
        add(1, 3, 3, 0, 8'h00, 1, 1, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 3, 3, 0, 8'h00, 1, 1, 1, 2, 16'h2222, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 2, 0, 0, 8'h00, 1, 9, 0, 0, 16'h0000, 0, 1, 1, 1, 16'h2222, 16'h0000, 1, 9, 0);
        add(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 0, 0, 0, 0, 0);

        foreach (vecs[k]) begin
            in_valid = vecs[k].iv; rs_addr = vecs[k].rs; rt_addr = vecs[k].rt;
            use_imm = vecs[k].ui; imm = vecs[k].im; op_in = vecs[k].opi;
            dest_in = vecs[k].dst; wb_en = vecs[k].wbe;
            wb_addr = vecs[k].wba; wb_data = vecs[k].wbd;
            flush = vecs[k].fl; out_ready = vecs[k].ordy;
            #1;
            chk($sformatf("v%0d in_ready", k), in_ready, vecs[k].e_rdy);
            cycle();
            chk($sformatf("v%0d out_valid", k), out_valid, vecs[k].e_v);
            if (vecs[k].e_v) begin
                chk($sformatf("v%0d A", k), A, vecs[k].e_a);
                chk($sformatf("v%0d B", k), B, vecs[k].e_b);
                chk($sformatf("v%0d op", k), op, vecs[k].e_op);
                chk($sformatf("v%0d dest", k), dest_out, vecs[k].e_dst);
                chk($sformatf("v%0d illegal", k), illegal_op, vecs[k].e_ill);
            end
        end

        // Reset while stalled drops the entry and clears every register.
        idle();
        in_valid = 1; rs_addr = 3; rt_addr = 5; op_in = 2; dest_in = 1;
        cycle();
        chk("pre-stall valid", out_valid, 1);
        idle();
        out_ready = 0;
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        chk("stall reset valid", out_valid, 0);
        chk("stall reset A", A, 0);
        for (int r = 1; r < 16; r++) begin
            idle();
            in_valid = 1; rs_addr = r[3:0]; rt_addr = r[3:0];
            cycle();
            chk($sformatf("r%0d A after reset", r), A, 0);
            chk($sformatf("r%0d B after reset", r), B, 0);
        end

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            in_valid = $urandom_range(0, 3) != 0;
            rs_addr = 4'($urandom_range(0, 15));
            rt_addr = 4'($urandom_range(0, 15));
            use_imm = $urandom_range(0, 1);
            imm = 8'($urandom);
            op_in = 4'($urandom_range(0, 15));
            dest_in = 4'($urandom_range(0, 15));
            wb_en = $urandom_range(0, 1);
            wb_addr = 4'($urandom_range(0, 15));
            wb_data = 16'($urandom);
            flush = ($urandom_range(0, 9) == 0);
            out_ready = $urandom_range(0, 2) != 0;
            #1;
            chk("rand in_ready", in_ready, !flush && (!m_v || out_ready));
            cycle();
            chk("rand out_valid", out_valid, m_v);
            if (m_v || m_rst) begin
                chk("rand A", A, m_a[15:0]);
                chk("rand B", B, m_b[15:0]);
                chk("rand op", op, m_op[3:0]);
                chk("rand dest", dest_out, m_dst[3:0]);
                chk("rand illegal", illegal_op, m_ill[0]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
